// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state and the 32-bit word.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;
endpackage

// File: rtl/ram_responder_if.sv
// RAM-side request/response bus between the memory controller and RAM.
interface ram_responder_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (output ramREN, ramWEN, ramaddr, ramstore,
                  input  ramload, ramstate);
  modport slave  (input  ramREN, ramWEN, ramaddr, ramstore,
                  output ramload, ramstate);
endinterface

// File: rtl/ram_responder_ram_array.sv
// Single-port word storage: asynchronous read, synchronous write enable.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  word_t             wdata,
  output word_t             rdata
);
  word_t mem [2**ADDR_W];

  // Write the addressed word on the clock edge; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/ram_responder.sv
// RAM endpoint with programmable access latency (LAT BUSY cycles, then ACCESS).
// Optional feature macro: RAM_ERRCHK_EN -- misaligned or out-of-range
// addresses answer ERROR instead of aliasing into the array.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 10
) (
  input logic       CLK,
  input logic       RST,
  ram_responder_if.slave bus
);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

  logic [CNT_W-1:0] cnt, eff_cnt, cnt_nxt;
  word_t            last_addr;
  logic             last_op, last_req;
  logic             req, conflict, change, addr_bad, we;
  logic [ADDR_W-1:0] idx;
  word_t            rdata;
  ramstate_t        state;

  assign req      = bus.ramREN ^ bus.ramWEN;
  assign conflict = bus.ramREN & bus.ramWEN;
  assign idx      = bus.ramaddr[ADDR_W+1:2];

`ifdef RAM_ERRCHK_EN
  assign addr_bad = (bus.ramaddr[1:0] != 2'b00) ||
                    (bus.ramaddr[31:ADDR_W+2] != '0);
`else
  assign addr_bad = 1'b0;
`endif

  // A new request (after idle, or new address/op) restarts the wait count.
  assign change = req && (!last_req || (bus.ramaddr != last_addr) ||
                          (bus.ramWEN != last_op));

  // Decode the handshake state, next count and write strobe.
  always_comb begin
    state   = FREE;
    cnt_nxt = '0;
    we      = 1'b0;
    eff_cnt = change ? '0 : cnt;
    if (RST) begin
      state = FREE;
    end else if (conflict) begin
      state = ERROR;
    end else if (!req) begin
      state = FREE;
    end else if (addr_bad) begin
      state = ERROR;
    end else if (eff_cnt < LAT_C) begin
      state   = BUSY;
      cnt_nxt = eff_cnt + 1'b1;
    end else begin
      state = ACCESS;
      we    = bus.ramWEN;
    end
  end

  // Wait counter and last-request tracking for change detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      last_addr <= '0;
      last_op   <= 1'b0;
      last_req  <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      last_addr <= bus.ramaddr;
      last_op   <= bus.ramWEN;
      last_req  <= req;
    end
  end

  ram_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (CLK),
    .we    (we),
    .idx   (idx),
    .wdata (bus.ramstore),
    .rdata (rdata)
  );

  assign bus.ramstate = state;
  assign bus.ramload  = (state == ACCESS && bus.ramREN) ? rdata : '0;
endmodule

// File: tb/tb_ram_responder.sv
// Bench: three responders (LAT 2, 0, 3) driven in lockstep and checked
// against a cycle-level reference model of the request/latency rules.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int LATS [3] = '{2, 0, 3};

  logic  clk = 1'b0;
  logic  rst, ren, wen;
  word_t addr, store;
  int    nchk = 0, nerr = 0, cyc = 0;

  ram_responder_if if0 ();
  ram_responder_if if1 ();
  ram_responder_if if2 ();

  assign if0.ramREN = ren;  assign if0.ramWEN = wen;
  assign if0.ramaddr = addr; assign if0.ramstore = store;
  assign if1.ramREN = ren;  assign if1.ramWEN = wen;
  assign if1.ramaddr = addr; assign if1.ramstore = store;
  assign if2.ramREN = ren;  assign if2.ramWEN = wen;
  assign if2.ramaddr = addr; assign if2.ramstore = store;

  ram_responder #(.LAT(2), .ADDR_W(10)) u0 (.CLK(clk), .RST(rst), .bus(if0));
  ram_responder #(.LAT(0), .ADDR_W(10)) u1 (.CLK(clk), .RST(rst), .bus(if1));
  ram_responder #(.LAT(3), .ADDR_W(10)) u2 (.CLK(clk), .RST(rst), .bus(if2));

  always #5 clk = ~clk;

  // reference model state
  int unsigned mem_m [int];
  bit          active [3];
  int          start  [3];
  word_t       paddr  [3];
  bit          pop    [3];
  logic [1:0]  obs_st [3];
  word_t       obs_ld [3];

  function automatic logic [1:0] get_st(int i);
    case (i)
      0: return if0.ramstate;
      1: return if1.ramstate;
      default: return if2.ramstate;
    endcase
  endfunction

  function automatic word_t get_ld(int i);
    case (i)
      0: return if0.ramload;
      1: return if1.ramload;
      default: return if2.ramload;
    endcase
  endfunction

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One bus cycle: drive, check every DUT against the model, clock, update.
  task automatic step(input logic r, input logic w, input word_t a,
                      input word_t d, input logic rs);
    ramstate_t es [3];
    int        s  [3];
    int        key;
    bit        bad;
    word_t     el;
    ren = r; wen = w; addr = a; store = d; rst = rs;
    #1;
`ifdef RAM_ERRCHK_EN
    bad = (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
`else
    bad = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      key  = i * 4096 + int'(a[11:2]);
      s[i] = cyc;
      if (rs)            es[i] = FREE;
      else if (r && w)   es[i] = ERROR;
      else if (!(r ^ w)) es[i] = FREE;
      else if (bad)      es[i] = ERROR;
      else begin
        if (active[i] && a == paddr[i] && w == pop[i]) s[i] = start[i];
        es[i] = (cyc - s[i] < LATS[i]) ? BUSY : ACCESS;
      end
      obs_st[i] = get_st(i);
      obs_ld[i] = get_ld(i);
      chk($sformatf("state[lat%0d]", LATS[i]), {30'd0, obs_st[i]}, {30'd0, es[i]});
      if (es[i] == ACCESS && r) begin
        if (mem_m.exists(key)) begin
          el = mem_m[key];
          chk($sformatf("load[lat%0d]", LATS[i]), obs_ld[i], el);
        end
      end else begin
        chk($sformatf("load0[lat%0d]", LATS[i]), obs_ld[i], 32'd0);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      key = i * 4096 + int'(a[11:2]);
      if (es[i] == BUSY || es[i] == ACCESS) begin
        active[i] = 1'b1;
        paddr[i]  = a;
        pop[i]    = w;
        start[i]  = (es[i] == ACCESS) ? cyc + 1 : s[i];
        if (es[i] == ACCESS && w) mem_m[key] = d;
      end else begin
        active[i] = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic hold(input logic r, input logic w, input word_t a,
                      input word_t d, input int n);
    for (int k = 0; k < n; k++) step(r, w, a, d, 1'b0);
  endtask

  initial begin
    word_t alist [8];
    int    op, len;
    word_t ra, rd;
    for (int i = 0; i < 3; i++) begin
      active[i] = 0; start[i] = 0; paddr[i] = 0; pop[i] = 0;
    end
    ren = 0; wen = 0; addr = 0; store = 0; rst = 1;
    @(negedge clk);

    // reset
    step(0, 0, 0, 0, 1);
    step(1, 0, 32'h40, 0, 1);
    chk("rst_state", {30'd0, obs_st[1]}, {30'd0, FREE});
    chk("rst_load", obs_ld[1], 32'd0);

    // preload 0x40, then read it held (LAT2: BUSY, BUSY, ACCESS)
    hold(0, 1, 32'h40, 32'hDEADBEEF, 4);
    step(0, 0, 0, 0, 0);
    step(1, 0, 32'h40, 0, 0);
    chk("rd_c0", {30'd0, obs_st[0]}, {30'd0, BUSY});
    step(1, 0, 32'h40, 0, 0);
    chk("rd_c1", {30'd0, obs_st[0]}, {30'd0, BUSY});
    step(1, 0, 32'h40, 0, 0);
    chk("rd_c2", {30'd0, obs_st[0]}, {30'd0, ACCESS});
    chk("rd_c2_data", obs_ld[0], 32'hDEADBEEF);
    step(0, 0, 32'h40, 0, 0);
    chk("rd_drop", {30'd0, obs_st[0]}, {30'd0, FREE});

    // write then immediate read (LAT2: write ACCESS cycle 2, read cycle 5)
    hold(0, 1, 32'h40, 32'h12345678, 3);
    hold(1, 0, 32'h40, 0, 3);
    chk("wr_rd_data", obs_ld[0], 32'h12345678);
    step(0, 0, 0, 0, 0);

    // LAT0 back-to-back writes at changing addresses
    step(0, 1, 32'h100, 32'hAAAA0001, 0);
    chk("b2b_w0", {30'd0, obs_st[1]}, {30'd0, ACCESS});
    step(0, 1, 32'h104, 32'hBBBB0002, 0);
    chk("b2b_w1", {30'd0, obs_st[1]}, {30'd0, ACCESS});
    step(1, 0, 32'h100, 0, 0);
    chk("b2b_r0", obs_ld[1], 32'hAAAA0001);
    step(1, 0, 32'h104, 0, 0);
    chk("b2b_r1", obs_ld[1], 32'hBBBB0002);
    step(0, 0, 0, 0, 0);

    // conflict: ERROR, no write
    hold(0, 1, 32'h80, 32'hC0C0C0C0, 4);
    step(0, 0, 0, 0, 0);
    hold(1, 1, 32'h80, 32'h0BAD0BAD, 3);
    chk("conflict", {30'd0, obs_st[2]}, {30'd0, ERROR});
    hold(1, 0, 32'h80, 0, 4);
    chk("conflict_nowr", obs_ld[2], 32'hC0C0C0C0);
    step(0, 0, 0, 0, 0);

    // LAT3 read with reset pulse in cycle 2, then full restart
    hold(1, 0, 32'h40, 0, 2);
    step(1, 0, 32'h40, 0, 1);
    chk("mid_rst", {30'd0, obs_st[2]}, {30'd0, FREE});
    hold(1, 0, 32'h40, 0, 3);
    chk("restart_busy", {30'd0, obs_st[2]}, {30'd0, BUSY});
    step(1, 0, 32'h40, 0, 0);
    chk("restart_acc", {30'd0, obs_st[2]}, {30'd0, ACCESS});
    step(0, 0, 0, 0, 0);

    // abandoned write: reset before ACCESS leaves old data
    hold(0, 1, 32'h44, 32'h00000011, 4);
    hold(0, 1, 32'h44, 32'h00000055, 2);
    step(0, 1, 32'h44, 32'h00000055, 1);
    step(0, 0, 0, 0, 0);
    hold(1, 0, 32'h44, 0, 4);
    chk("abandon_wr", obs_ld[2], 32'h00000011);
    step(0, 0, 0, 0, 0);

    // address aliasing / error checking
    hold(0, 1, 32'h0, 32'h0000A1A5, 4);
    step(0, 0, 0, 0, 0);
    hold(1, 0, 32'h1000, 0, 4);
`ifdef RAM_ERRCHK_EN
    chk("range_err", {30'd0, obs_st[2]}, {30'd0, ERROR});
    step(1, 0, 32'h42, 0, 0);
    chk("align_err", {30'd0, obs_st[1]}, {30'd0, ERROR});
    step(1, 0, 32'h00010000, 0, 0);
    chk("high_err", {30'd0, obs_st[1]}, {30'd0, ERROR});
`else
    chk("alias_rd", obs_ld[2], 32'h0000A1A5);
    step(1, 0, 32'h42, 0, 0);
    chk("align_ignored", {30'd0, obs_st[1]}, {30'd0, ACCESS});
`endif
    step(0, 0, 0, 0, 0);

    // randomized traffic
    alist = '{32'h40, 32'h44, 32'h100, 32'h104, 32'h1000, 32'h42, 32'h10040, 32'h0};
    for (int n = 0; n < 150; n++) begin
      op  = $urandom_range(0, 9);
      len = $urandom_range(1, 5);
      ra  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h00000ffc)
                                         : alist[$urandom_range(0, 7)];
      rd  = $urandom;
      for (int k = 0; k < len; k++)
        step(op >= 2 && op <= 5 || op == 1, op >= 6 || op == 1, ra, rd,
             $urandom_range(0, 29) == 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
